// File: rtl/mux_sched_pkg.sv
// ============================================================================
// Module  : mux_sched_pkg
// Brief   : Shared sizes, state encoding and helpers for mux_rr_scheduler.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mux_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux_rr_scheduler_if.sv
// ============================================================================
// Module  : mux_rr_scheduler_if
// Brief   : Request/data/grant bundle between scheduler and its environment.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mux_rr_scheduler_if;
  import mux_sched_pkg::*;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] i;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             o;
  logic             o_valid;
  logic             busy;

  modport master (
    output en, req, i,
    input  sel, gnt, o, o_valid, busy
  );

  modport slave (
    input  en, req, i,
    output sel, gnt, o, o_valid, busy
  );

endinterface

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module  : rr_pick
// Brief   : Finds the first asserted request at or after ptr, wrapping around.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import mux_sched_pkg::*;
(
  input  wire logic [N_REQ-1:0] i_req,
  input  wire logic [SEL_W-1:0] i_ptr,
  output logic                  o_found,
  output logic [SEL_W-1:0]      o_idx
);

  // Scan from farthest to nearest so the nearest hit overwrites the others.
  always_comb begin
    o_found = 1'b0;
    o_idx   = i_ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (i_req[i_ptr + SEL_W'(k)]) begin
        o_found = 1'b1;
        o_idx   = i_ptr + SEL_W'(k);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mux_rr_scheduler.sv
// ============================================================================
// Module  : mux_rr_scheduler
// Brief   : Round-robin burst-limited grant of an 8:1 bit mux, registered out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_rr_scheduler
  import mux_sched_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  mux_rr_scheduler_if.slave  bus
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [SEL_W-1:0]   w_sel_nxt;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   w_ptr_nxt;
  logic               r_o;
  logic               r_o_valid;

  logic [SEL_W-1:0]   w_pick_ptr;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;
  logic               w_release;
  logic               w_data;

  // While granting, arbitration looks ahead from the pointer a release would set.
  assign w_pick_ptr = (r_state == GRANT) ? (r_sel + SEL_W'(1)) : r_ptr;

  rr_pick u_pick (
    .i_req   (bus.req),
    .i_ptr   (w_pick_ptr),
    .o_found (w_found),
    .o_idx   (w_idx)
  );

  assign w_data = bus.i[r_sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    w_release   = 1'b0;
    case (r_state)
      IDLE: begin
        w_gnt_nxt = '0;
        w_cnt_nxt = '0;
        if (bus.en && w_found) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_gnt_nxt   = onehot(w_idx);
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      GRANT: begin
        w_release = !bus.req[r_sel] || (r_cnt == CNT_W'(MAX_BURST)) || !bus.en;
        if (w_release) begin
          w_ptr_nxt = r_sel + SEL_W'(1);
          if (bus.en && w_found) begin
            w_sel_nxt = w_idx;
            w_gnt_nxt = onehot(w_idx);
            w_cnt_nxt = CNT_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_cnt_nxt   = '0;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel     <= '0;
      r_gnt     <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_o       <= 1'b0;
      r_o_valid <= 1'b0;
    end else begin
      r_sel     <= w_sel_nxt;
      r_gnt     <= w_gnt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_o_valid <= (r_state == GRANT);
      if (r_state == GRANT) begin
        r_o <= w_data;
      end
    end
  end

  assign bus.sel     = r_sel;
  assign bus.gnt     = r_gnt;
  assign bus.o       = r_o;
  assign bus.o_valid = r_o_valid;
  assign bus.busy    = (r_state == GRANT);

endmodule

`default_nettype wire
